scd_trap_seq: RTL and testbench
===============================

# scd_trap_seq

Trap request sequencer directly downstream of the SCD board. Samples the SCD trap-request flags (`scd4_trap_req_1_h`, `scd4_trap_req_2_h`) at each instruction-boundary NICOND strobe and latches a trap code. Presents a held trap-cycle request with its EPT/UPT vector offset to CON using a req/ack handshake. Enforces a post-trap holdoff so the same flags are not resampled before microcode clears them. An optional diagnostic readback is available on the EBUS.

## Interface
Parameters:
- `HOLDOFF`, default 3: number of cycles to ignore sample strobes after an ack. Legal range 1..15.

Ports:
- `clk3_trp_h`  in  1  board clock; all state changes on its rising edge.
- `mr_reset_02_l`  in  1  reset; one clock, synchronous, active-low.
- `scd4_trap_req_1_h`  in  1  SCD trap 1 flag (arithmetic overflow).
- `scd4_trap_req_2_h`  in  1  SCD trap 2 flag (pushdown overflow).
- `scd5_user_a_h`  in  1  user mode; selects UPT (1) or EPT (0) vector.
- `con_nicond_trap_en_h`  in  1  instruction-boundary sample strobe.
- `con_pi_cycle_a_l`  in  1  low means a PI cycle is in progress; blocks sampling.
- `con_trap_ack_h`  in  1  CON has accepted the trap cycle.
- `con_cond_instr_abort_h`  in  1  cancels an unacknowledged request.
- `diag_read_func_13x_l`  in  1  low enables the diagnostic EBUS drive.
- `trp_req_h`  out  1  trap cycle request.
- `trp_code_h`  out  2  latched trap code, {req_2, req_1}; values 1..3.
- `trp_vma_h`  out  9  vector offset = 9'o420 + code, i.e. 0421, 0422 or 0423.
- `trp_upt_h`  out  1  vector lives in UPT.
- `trp_busy_h`  out  1  state is not IDLE.
- `ebus_trp_h`  out  12  diagnostic readback word.

## Operation
- Three states, encoded as 2 bits: IDLE=0, REQ=1, HOLD=2. Encoding 3 is illegal and goes to IDLE on the next edge.
- IDLE: sample when `con_nicond_trap_en_h`=1, `con_pi_cycle_a_l`=1, and {req_2, req_1} is not 0.
  - On a sample, latch the code, compute `trp_vma_h` from it, and latch `trp_upt_h` from `scd5_user_a_h`.
  - Set `trp_req_h` and go to REQ.
- IDLE, no sample: if the code is 0, or a PI cycle is active at the strobe, no action. The trap is retaken at the next boundary strobe.
- REQ: `trp_req_h`, `trp_code_h`, `trp_vma_h` and `trp_upt_h` are held stable. Input flag changes are ignored.
- REQ with `con_trap_ack_h`=1:
  - Clear `trp_req_h`, load the holdoff counter with `HOLDOFF`, and go to HOLD.
  - Increment the taken-counter (only with the diag macro), saturating at 255.
- REQ with abort=1 and ack=0: clear `trp_req_h`, go to IDLE, no count.
- Ack and abort in the same cycle: ack wins.
- HOLD: decrement the counter each cycle and ignore strobes. When the counter reaches 0, go to IDLE.
- Ack while in IDLE or HOLD is ignored. Abort while in IDLE or HOLD is ignored.
- Code and vector registers retain their last value after REQ exits, until the next sample.

## Timing
- Reset (`mr_reset_02_l`=0 at an edge) has this effect after that edge:
  - state IDLE;
  - `trp_req_h`=0, `trp_code_h`=0, `trp_vma_h`=0, `trp_upt_h`=0, `trp_busy_h`=0, `ebus_trp_h`=0;
  - holdoff counter and taken-counter = 0.
- Reset overrides everything, including a pending REQ; no ack is needed.
- All outputs are registered except `ebus_trp_h`, which is combinational from the registers and `diag_read_func_13x_l`.
- Sample at edge N: `trp_req_h` is high from edge N onward and the code/vector are valid in the same cycle.
- Ack sampled at edge M: `trp_req_h` is low after M.
  - HOLD occupies exactly `HOLDOFF` cycles.
  - The earliest honoured strobe is at edge M+HOLDOFF+1.
- Minimum request width is 1 cycle (ack may be high in the first REQ cycle).
- Back-to-back traps are separated by at least `HOLDOFF`+1 cycles of `trp_req_h`=0.

## Configuration
- `SCD_TRAP_DIAG_EN` defined:
  - 8-bit saturating taken-counter is present.
  - When `diag_read_func_13x_l`=0, `ebus_trp_h` = {state[1:0], code[1:0], count[7:0]}; otherwise it is 0.
- `SCD_TRAP_DIAG_EN` undefined: no counter is built, and `ebus_trp_h` is constant 0.
- Trap behaviour is identical with and without the macro.

## Test plan
- Reset, then req_1=1 with a strobe and PI idle, and `scd5_user_a_h`=0:
  - next cycle `trp_req_h`=1, code=1, `trp_vma_h`=9'o421, `trp_upt_h`=0;
  - ack 3 cycles later, then `trp_req_h`=0 and 3 HOLD cycles, then IDLE.
- Both flags set, user=1: code=3, vma=9'o423, upt=1. A strobe during HOLD (`HOLDOFF`=3) is ignored; a strobe at M+4 is taken.
- Strobe with `con_pi_cycle_a_l`=0 and flags set: no request. The next strobe with PI idle takes the trap.
- REQ plus abort → IDLE, count unchanged. REQ with ack and abort in the same cycle → HOLD, count+1.
- With `SCD_TRAP_DIAG_EN`:
  - 300 ack'd traps → count reads 255;
  - reading while in REQ with code 2 gives `ebus_trp_h`=12'b01_10_11111111;
  - with `diag_read_func_13x_l`=1 the bus reads 0.
- Reset asserted mid-REQ: all outputs 0 on the next cycle, and a following ack is ignored.

Source files
------------

// File: rtl/scd_trap_seq.sv
// Trap request sequencer behind the SCD board: samples trap flags at NICOND and holds a trap-cycle request for CON.
// Optional diagnostic taken-counter and EBUS readback are built when SCD_TRAP_DIAG_EN is defined.
module scd_trap_seq #(
  parameter int unsigned HOLDOFF = 3
) (
  input  logic        clk3_trp_h,
  input  logic        mr_reset_02_l,
  input  logic        scd4_trap_req_1_h,
  input  logic        scd4_trap_req_2_h,
  input  logic        scd5_user_a_h,
  input  logic        con_nicond_trap_en_h,
  input  logic        con_pi_cycle_a_l,
  input  logic        con_trap_ack_h,
  input  logic        con_cond_instr_abort_h,
  input  logic        diag_read_func_13x_l,
  output logic        trp_req_h,
  output logic [1:0]  trp_code_h,
  output logic [8:0]  trp_vma_h,
  output logic        trp_upt_h,
  output logic        trp_busy_h,
  output logic [11:0] ebus_trp_h
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF);
  localparam logic [8:0] VMA_BASE  = 9'o420;

  state_t     state;
  logic [3:0] hold_cnt;
  logic [1:0] flags;
  logic       sample;

  assign flags  = {scd4_trap_req_2_h, scd4_trap_req_1_h};
  assign sample = con_nicond_trap_en_h & con_pi_cycle_a_l & (flags != 2'b00);

`ifdef SCD_TRAP_DIAG_EN
  logic [7:0] taken_cnt;
`endif

  // NOTE: all state is written with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk3_trp_h) begin
    if (!mr_reset_02_l) begin
      state      <= ST_IDLE;
      hold_cnt   <= 4'd0;
      trp_req_h  <= 1'b0;
      trp_code_h <= 2'b00;
      trp_vma_h  <= 9'd0;
      trp_upt_h  <= 1'b0;
      trp_busy_h <= 1'b0;
`ifdef SCD_TRAP_DIAG_EN
      taken_cnt  <= 8'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (sample) begin
            state      <= ST_REQ;
            trp_req_h  <= 1'b1;
            trp_code_h <= flags;
            trp_vma_h  <= VMA_BASE + {7'd0, flags};
            trp_upt_h  <= scd5_user_a_h;
            trp_busy_h <= 1'b1;
          end
        end
        ST_REQ: begin
          // Ack takes priority over abort when both arrive together.
          if (con_trap_ack_h) begin
            state     <= ST_HOLD;
            trp_req_h <= 1'b0;
            hold_cnt  <= HOLD_LOAD;
`ifdef SCD_TRAP_DIAG_EN
            if (taken_cnt != 8'hFF) taken_cnt <= taken_cnt + 8'd1;
`endif
          end else if (con_cond_instr_abort_h) begin
            state      <= ST_IDLE;
            trp_req_h  <= 1'b0;
            trp_busy_h <= 1'b0;
          end
        end
        ST_HOLD: begin
          // Leaving on the edge where the count hits zero gives exactly HOLDOFF cycles in HOLD.
          hold_cnt <= hold_cnt - 4'd1;
          if (hold_cnt <= 4'd1) begin
            state      <= ST_IDLE;
            trp_busy_h <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          hold_cnt   <= 4'd0;
          trp_req_h  <= 1'b0;
          trp_busy_h <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCD_TRAP_DIAG_EN
  assign ebus_trp_h = diag_read_func_13x_l ? 12'd0 : {state, trp_code_h, taken_cnt};
`else
  logic unused_diag;
  assign unused_diag = diag_read_func_13x_l;
  assign ebus_trp_h  = 12'd0;
`endif

  a_req_has_code: assert property (@(posedge clk3_trp_h) trp_req_h |-> (trp_code_h != 2'b00));
  a_req_is_busy:  assert property (@(posedge clk3_trp_h) trp_req_h |-> trp_busy_h);

endmodule

// File: tb/tb_scd_trap_seq.sv
// Self-checking bench for scd_trap_seq: cycle-level behavioural model compared every cycle plus directed literals.
module tb_scd_trap_seq;
  localparam int HOLDOFF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l, r1, r2, user, strobe, pi_l, ack, abort, diag_l;
  logic        trp_req_h, trp_upt_h, trp_busy_h;
  logic [1:0]  trp_code_h;
  logic [8:0]  trp_vma_h;
  logic [11:0] ebus_trp_h;

  scd_trap_seq #(.HOLDOFF(HOLDOFF)) dut (
    .clk3_trp_h            (clk),
    .mr_reset_02_l         (rst_l),
    .scd4_trap_req_1_h     (r1),
    .scd4_trap_req_2_h     (r2),
    .scd5_user_a_h         (user),
    .con_nicond_trap_en_h  (strobe),
    .con_pi_cycle_a_l      (pi_l),
    .con_trap_ack_h        (ack),
    .con_cond_instr_abort_h(abort),
    .diag_read_func_13x_l  (diag_l),
    .trp_req_h             (trp_req_h),
    .trp_code_h            (trp_code_h),
    .trp_vma_h             (trp_vma_h),
    .trp_upt_h             (trp_upt_h),
    .trp_busy_h            (trp_busy_h),
    .ebus_trp_h            (ebus_trp_h)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request is pending or not; after an ack, strobes are honoured again from edge M+HOLDOFF+1.
  int         cyc = 0;
  int         allow_cyc = 0;
  int         m_count = 0;
  logic       model_valid = 1'b0;
  logic       m_req = 1'b0, m_upt = 1'b0;
  logic [1:0] m_code = 2'b00;
  logic [8:0] m_vma = 9'd0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_l) begin
      m_req = 1'b0; m_code = 2'b00; m_vma = 9'd0; m_upt = 1'b0;
      m_count = 0; allow_cyc = 0; model_valid = 1'b1;
    end else if (model_valid) begin
      if (m_req) begin
        if (ack) begin
          m_req = 1'b0;
          allow_cyc = cyc + HOLDOFF + 1;
          if (m_count < 255) m_count++;
        end else if (abort) begin
          m_req = 1'b0;
        end
      end else if (cyc >= allow_cyc && strobe && pi_l && (r1 || r2)) begin
        m_req = 1'b1;
        m_code = {r2, r1};
        m_vma = 9'o420 + 9'(m_code);
        m_upt = user;
      end
    end
  end

  always @(negedge clk) begin
    logic        m_busy;
    logic [1:0]  m_st;
    logic [11:0] m_ebus;
    if (model_valid) begin
      m_busy = m_req || (cyc < allow_cyc - 1);
      m_st   = m_req ? 2'd1 : (m_busy ? 2'd2 : 2'd0);
`ifdef SCD_TRAP_DIAG_EN
      m_ebus = diag_l ? 12'd0 : {m_st, m_code, 8'(m_count)};
`else
      m_ebus = 12'd0;
      if (m_st == 2'd3) m_ebus = 12'd1;
`endif
      check("cyc_req",  32'(trp_req_h),  32'(m_req));
      check("cyc_code", 32'(trp_code_h), 32'(m_code));
      check("cyc_vma",  32'(trp_vma_h),  32'(m_vma));
      check("cyc_upt",  32'(trp_upt_h),  32'(m_upt));
      check("cyc_busy", 32'(trp_busy_h), 32'(m_busy));
      check("cyc_ebus", 32'(ebus_trp_h), 32'(m_ebus));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic take_trap(input logic [1:0] f, input logic u);
    {r2, r1} = f; user = u; strobe = 1'b1;
    tick();
    strobe = 1'b0; {r2, r1} = 2'b00;
  endtask

  task automatic ack_and_drain();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (HOLDOFF) tick();
  endtask

  initial begin
    rst_l = 1'b0; r1 = 1'b0; r2 = 1'b0; user = 1'b0; strobe = 1'b0;
    pi_l = 1'b1; ack = 1'b0; abort = 1'b0; diag_l = 1'b1;
    tick();
    rst_l = 1'b1;
    check("rst_req", 32'(trp_req_h), 0);
    check("rst_code", 32'(trp_code_h), 0);
    check("rst_vma", 32'(trp_vma_h), 0);
    check("rst_busy", 32'(trp_busy_h), 0);
    check("rst_ebus", 32'(ebus_trp_h), 0);

    // Basic trap 1, executive mode.
    take_trap(2'b01, 1'b0);
    check("t1_req", 32'(trp_req_h), 1);
    check("t1_code", 32'(trp_code_h), 1);
    check("t1_vma", 32'(trp_vma_h), 32'(9'o421));
    check("t1_upt", 32'(trp_upt_h), 0);
    repeat (2) tick();
    check("t1_held", 32'(trp_req_h), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t1_ack_req", 32'(trp_req_h), 0);
    check("t1_hold_busy", 32'(trp_busy_h), 1);
    check("t1_code_kept", 32'(trp_vma_h), 32'(9'o421));
    repeat (2) tick();
    check("t1_hold_last", 32'(trp_busy_h), 1);
    tick();
    check("t1_idle", 32'(trp_busy_h), 0);

    // Both flags in user mode; strobes during HOLD ignored, M+4 taken.
    take_trap(2'b11, 1'b1);
    check("t3_code", 32'(trp_code_h), 3);
    check("t3_vma", 32'(trp_vma_h), 32'(9'o423));
    check("t3_upt", 32'(trp_upt_h), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    strobe = 1'b1; r1 = 1'b1; user = 1'b0;
    repeat (3) begin
      tick();
      check("hold_strobe_ignored", 32'(trp_req_h), 0);
    end
    tick();
    strobe = 1'b0; r1 = 1'b0;
    check("m4_taken", 32'(trp_req_h), 1);
    check("m4_code", 32'(trp_code_h), 1);
    ack_and_drain();

    // PI cycle blocks sampling; next strobe with PI idle takes it.
    r2 = 1'b1; strobe = 1'b1; pi_l = 1'b0;
    tick();
    check("pi_blocked", 32'(trp_req_h), 0);
    pi_l = 1'b1;
    tick();
    strobe = 1'b0; r2 = 1'b0;
    check("pi_retake", 32'(trp_req_h), 1);
    check("pi_vma", 32'(trp_vma_h), 32'(9'o422));
    diag_l = 1'b0;
    #1;
`ifdef SCD_TRAP_DIAG_EN
    check("ebus_req_code2", 32'(ebus_trp_h), 32'({2'b01, 2'b10, 8'd3}));
`else
    check("ebus_off", 32'(ebus_trp_h), 0);
`endif
    diag_l = 1'b1;

    // Abort alone drops to IDLE; ack with abort goes to HOLD.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_req", 32'(trp_req_h), 0);
    check("abort_busy", 32'(trp_busy_h), 0);
    take_trap(2'b01, 1'b0);
    ack = 1'b1; abort = 1'b1;
    tick();
    ack = 1'b0; abort = 1'b0;
    check("ackabort_busy", 32'(trp_busy_h), 1);
    repeat (HOLDOFF) tick();

    // Reset in the middle of a request; a later ack must not matter.
    take_trap(2'b10, 1'b1);
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    check("midrst_req", 32'(trp_req_h), 0);
    check("midrst_code", 32'(trp_code_h), 0);
    check("midrst_upt", 32'(trp_upt_h), 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("midrst_ack_busy", 32'(trp_busy_h), 0);

    // Saturation of the taken-counter.
    for (int i = 0; i < 300; i++) begin
      take_trap(2'b01, 1'b0);
      ack_and_drain();
    end
    take_trap(2'b10, 1'b0);
    diag_l = 1'b0;
    #1;
`ifdef SCD_TRAP_DIAG_EN
    check("ebus_sat", 32'(ebus_trp_h), 32'(12'b01_10_11111111));
`else
    check("ebus_sat_off", 32'(ebus_trp_h), 0);
`endif
    diag_l = 1'b1;
    #1;
    check("ebus_disabled", 32'(ebus_trp_h), 0);
    ack_and_drain();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
